alu_display_seq: RTL and testbench
==================================

Name: alu_display_seq

Overview:
Parametrised successor of the 3-bit ALU + display top.
- Latches WIDTH-bit operands on a Start handshake.
- Executes add/sub in one cycle, and multiply/divide iteratively over WIDTH cycles.
- Presents a 2*WIDTH-bit result with Busy/Done/Error flags.
- Scans the result in hex onto a DIGITS-wide multiplexed 7-segment display.
- Sits directly under the board top, driven by switches/buttons.

Parameters:
WIDTH, 4, operand width in bits (legal 2..8).
DIGITS, 4, number of 7-seg digits scanned (legal 1..8; 4*DIGITS >= 2*WIDTH for full visibility).
REFRESH_DIV, 16, refresh counter width; the digit advances every 2^REFRESH_DIV clocks.

Ports:
Clock  in  1  system clock.
Reset  in  1  asynchronous, active-low reset.
Start  in  1  request; sampled only in IDLE.
Opcode  in  2  00 add, 01 sub, 10 mul, 11 div.
PortA  in  WIDTH  operand A, unsigned.
PortB  in  WIDTH  operand B, unsigned.
Busy  out  1  operation in progress.
Done  out  1  one-cycle completion pulse.
Result  out  2*WIDTH  registered result.
Error  out  1  borrow or divide-by-zero flag of the last operation.
An  out  DIGITS  digit enables, active-low, one-hot.
Sseg  out  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
Reset (Reset=0, async):
- Result=0, Error=0, Busy=0, Done=0.
- FSM goes to IDLE; refresh counter and digit index go to 0.
- An=all ones, Sseg=7'h7F.

FSM states: IDLE, ADDSUB, MUL, DIV, DONE.
- IDLE: Start=1 latches PortA, PortB and Opcode. Next state is ADDSUB (op 00/01), MUL (10) or DIV (11).
- ADDSUB: one cycle, then DONE.
- MUL/DIV: iteration counter runs WIDTH cycles, then DONE.
- DONE: one cycle, then IDLE.

Latency (Start high in cycle k):
- Add/sub: Done=1 in cycle k+2.
- Mul/div: Done=1 in cycle k+WIDTH+1.
- Busy=1 from k+1 through the Done cycle inclusive, 0 in IDLE.
- Result and Error load on the edge entering DONE and hold until the next DONE.

Handshake:
- Start while Busy is ignored; operands are not re-sampled.
- Start held high re-triggers in the IDLE cycle after DONE.
- Reset mid-operation aborts; Done never pulses for the aborted operation.

Arithmetic (all unsigned, results zero-extended to 2*WIDTH):
- Add: A+B; carry lands in bit WIDTH. Error=0.
- Sub: low WIDTH bits = (A-B) mod 2^WIDTH, upper bits 0. Error=1 iff B>A.
- Mul: shift-add, one partial product per cycle; Result = A*B. Error=0.
- Div: restoring division, one quotient bit per cycle.
  - Result[WIDTH-1:0] = quotient, Result[2W-1:W] = remainder. Error=0.
  - B==0: full latency still applies; quotient=all ones, remainder=A, Error=1.

Display:
- Refresh counter free-runs, independent of the FSM.
- On counter wrap, the digit index increments, wrapping from DIGITS-1 to 0.
- An and Sseg are registered and update on the same edge, so there is never a digit/segment mismatch.
- An bit i=0 selects digit i, which shows Result nibble i in hex.
- Nibbles beyond 2*WIDTH bits show 0.
- The display shows the held Result, including while Busy.

Optional Feature:
ALU_DISP_LZB_EN — leading-zero blanking.
- Defined: digits above the most significant non-zero nibble of Result output Sseg=7'h7F, while An still scans. Digit 0 is always shown, so Result=0 shows a single "0".
- Undefined: all DIGITS digits are shown, including leading zeros.

Decomposition:
Package alu_disp_pkg:
- opcode localparams (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
- FSM state encoding.
- hex-to-7seg font function (active-low; 0=7'h40, 1=7'h79, E=7'h06).

Sub-module seg_scan:
- holds the refresh counter, digit index, nibble select, blanking and font lookup.
- parameters DIGITS, REFRESH_DIV, DATA_W.
- The ALU FSM and datapath stay in alu_display_seq.

Test Plan:
(Bench settings: WIDTH=4, DIGITS=4, REFRESH_DIV=2.)
1. Add F+1: Start at cycle k -> Result=8'h10, Error=0, Done pulse at k+2 only, Busy high for k+1..k+2.
2. Sub 3-5 -> Result=8'h0E, Error=1; then sub 5-3 -> Result=8'h02, Error=0.
3. Mul F*F -> Result=8'hE1, Done at k+5, Busy high 5 cycles; Start pulsed at k+2 is ignored.
4. Div D/4 -> Result=8'h13 (rem 1, quo 3), Error=0; div 7/0 -> Result=8'h7F, Error=1, Done at k+5.
5. Reset=0 asserted at k+3 during a mul -> Busy=0, Result=0, An=4'hF immediately; no Done; a new add works normally afterwards.
6. Result=8'hE1 -> An scans 1110/1101/1011/0111, each for 4 cycles, with Sseg 79/06/40/40; with ALU_DISP_LZB_EN the upper two digits show 7F.

Source files
------------

// File: rtl/alu_disp_pkg.sv
// Shared definitions for the ALU + 7-segment display block: opcodes,
// FSM state encoding and the active-low hex font.
package alu_disp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDSUB = 3'd1,
    ST_MUL    = 3'd2,
    ST_DIV    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/alu_display_seq_seg_scan.sv
// Multiplexed hex display scanner: refresh counter, digit index and font lookup.
// ALU_DISP_LZB_EN enables leading-zero blanking (digit 0 always shown).
module seg_scan
  import alu_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 16,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  output logic [DIGITS-1:0] an_o,
  output logic [6:0]        sseg_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW    = 4 * DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [REFRESH_DIV-1:0] refresh_q, refresh_d;
  logic [IDX_W-1:0]       digit_q, digit_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic [6:0]             sseg_q, sseg_d;
  logic [PW-1:0]          padded;
  logic [3:0]             nibble;
  logic                   blank;
`ifdef ALU_DISP_LZB_EN
  logic [IDX_W-1:0]       msn;
`endif

  // Nibbles above DATA_W read as zero.
  assign padded = PW'(data_i);

  always_comb begin
    refresh_d = refresh_q + REFRESH_DIV'(1);
    digit_d   = digit_q;
    if (&refresh_q) begin
      digit_d = (digit_q == IDX_LAST) ? '0 : digit_q + IDX_W'(1);
    end
    nibble = padded[4*int'(digit_d) +: 4];
`ifdef ALU_DISP_LZB_EN
    msn = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (padded[4*i +: 4] != 4'h0) msn = IDX_W'(i);
    end
    blank = (digit_d > msn);
`else
    blank = 1'b0;
`endif
    // Enable and segments come from the same digit_d so they switch together.
    an_d   = ~(DIGITS'(1) << digit_d);
    sseg_d = blank ? 7'h7F : hex_to_seg(nibble);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      digit_q   <= '0;
      an_q      <= '1;
      sseg_q    <= 7'h7F;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
      sseg_q    <= sseg_d;
    end
  end

  assign an_o   = an_q;
  assign sseg_o = sseg_q;

endmodule

// File: rtl/alu_display_seq.sv
// Sequential unsigned ALU (1-cycle add/sub, WIDTH-cycle mul/div) driving a
// scanned hex display. ALU_DISP_LZB_EN selects leading-zero blanking in seg_scan.
module alu_display_seq
  import alu_disp_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [1:0]         opcode_i,
  input  logic [WIDTH-1:0]   port_a_i,
  input  logic [WIDTH-1:0]   port_b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               error_o,
  output logic [DIGITS-1:0]  an_o,
  output logic [6:0]         sseg_o,
  output state_t             dbg_state_o
);

  localparam int RW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Handshake: start_i is sampled only in IDLE; busy_o is high from the cycle
  // after acceptance through the done_o cycle; done_o pulses for one cycle
  // together with the new result_o/error_o, which then hold until the next done.
  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    result_q, result_d;
  logic             error_q, error_d;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [RW-1:0]    mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] div_quo;

  always_comb begin
    add_sum   = {1'b0, a_q} + {1'b0, b_q};
    sub_diff  = a_q - b_q;
    mul_sum   = acc_q + (shreg_q[0] ? mcand_q : '0);
    // Restoring step; with b_q == 0 every trial succeeds, giving quotient all ones.
    div_trial = {rem_q, shreg_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, b_q});
    div_rem   = div_ge ? (div_trial - {1'b0, b_q}) : div_trial;
    div_quo   = {shreg_q[WIDTH-2:0], div_ge};

    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    shreg_d  = shreg_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = opcode_i;
          a_d     = port_a_i;
          b_d     = port_b_i;
          cnt_d   = '0;
          acc_d   = '0;
          rem_d   = '0;
          mcand_d = RW'(port_a_i);
          shreg_d = (opcode_i == OP_MUL) ? port_b_i : port_a_i;
          case (opcode_i)
            OP_MUL:  state_d = ST_MUL;
            OP_DIV:  state_d = ST_DIV;
            default: state_d = ST_ADDSUB;
          endcase
        end
      end
      ST_ADDSUB: begin
        state_d = ST_DONE;
        if (op_q == OP_ADD) begin
          result_d = RW'(add_sum);
          error_d  = 1'b0;
        end else begin
          result_d = RW'(sub_diff);
          error_d  = (b_q > a_q);
        end
      end
      ST_MUL: begin
        acc_d   = mul_sum;
        mcand_d = mcand_q << 1;
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          result_d = mul_sum;
          error_d  = 1'b0;
        end
      end
      ST_DIV: begin
        rem_d   = div_rem[WIDTH-1:0];
        shreg_d = div_quo;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          result_d = {div_rem[WIDTH-1:0], div_quo};
          error_d  = (b_q == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      shreg_q  <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shreg_q  <= shreg_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign result_o    = result_q;
  assign error_o     = error_q;
  assign dbg_state_o = state_q;

  seg_scan #(
    .DIGITS     (DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .DATA_W     (RW)
  ) u_seg_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .data_i(result_q),
    .an_o  (an_o),
    .sseg_o(sseg_o)
  );

endmodule

// File: tb/tb_alu_display_seq.sv
// Directed bench for alu_display_seq (WIDTH=4, DIGITS=4, REFRESH_DIV=2);
// expected digit blanking follows ALU_DISP_LZB_EN.
module tb_alu_display_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] opcode = 2'b00;
  logic [3:0] pa = '0, pb = '0;
  logic       busy, done, error;
  logic [7:0] result;
  logic [3:0] an;
  logic [6:0] sseg;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];

  alu_display_seq #(.WIDTH(4), .DIGITS(4), .REFRESH_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .opcode_i(opcode),
    .port_a_i(pa), .port_b_i(pb), .busy_o(busy), .done_o(done),
    .result_o(result), .error_o(error), .an_o(an), .sseg_o(sseg),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(result), 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", 32'(result), 32'(e[7:0]));
          check("sb_error", 32'(error), 32'(e[8]));
        end
      end
    end
  end

  // Issue one operation, check busy/done cycle by cycle; poke re-pulses start mid-op.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] er, input logic ee,
                        input bit poke);
    int lat;
    lat = op[1] ? 5 : 2;
    @(negedge clk);
    start = 1'b1; opcode = op; pa = a; pb = b;
    exp_q.push_back({ee, er});
    for (int j = 1; j <= lat + 1; j++) begin
      @(negedge clk);
      check($sformatf("%s_busy_c%0d", nm, j), 32'(busy), 32'(j <= lat));
      check($sformatf("%s_done_c%0d", nm, j), 32'(done), 32'(j == lat));
      start = poke && (j == 2);
      if (poke && j == 2) begin
        opcode = 2'b00; pa = 4'h1; pb = 4'h2;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] prev;
    bit found;
    logic [6:0] exp_seg[4];
    logic [3:0] exp_an[4];
    bit rb[5], rd[5];

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_an", 32'(an), 32'hF);
    check("rst_sseg", 32'(sseg), 32'h7F);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("add_f1", 2'b00, 4'hF, 4'h1, 8'h10, 1'b0, 1'b0);
    run_op("sub_35", 2'b01, 4'h3, 4'h5, 8'h0E, 1'b1, 1'b0);
    run_op("sub_53", 2'b01, 4'h5, 4'h3, 8'h02, 1'b0, 1'b0);
    run_op("mul_ff", 2'b10, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b1);
    run_op("div_d4", 2'b11, 4'hD, 4'h4, 8'h13, 1'b0, 1'b0);
    run_op("div_70", 2'b11, 4'h7, 4'h0, 8'h7F, 1'b1, 1'b0);

    // Start held high: re-triggers in the IDLE cycle after DONE.
    rb = '{1, 1, 0, 1, 1};
    rd = '{0, 1, 0, 0, 1};
    @(negedge clk);
    start = 1'b1; opcode = 2'b00; pa = 4'h1; pb = 4'h2;
    exp_q.push_back(9'h003);
    exp_q.push_back(9'h003);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check($sformatf("hold_busy_c%0d", j), 32'(busy), 32'(rb[j-1]));
      check($sformatf("hold_done_c%0d", j), 32'(done), 32'(rd[j-1]));
      if (j == 4) start = 1'b0;
    end
    @(negedge clk);
    check("hold_idle_busy", 32'(busy), 32'd0);

    // Reset during a multiply aborts it with no done pulse.
    @(negedge clk);
    start = 1'b1; opcode = 2'b10; pa = 4'h3; pb = 4'h3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_error", 32'(error), 32'd0);
    check("abort_an", 32'(an), 32'hF);
    check("abort_sseg", 32'(sseg), 32'h7F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_op("add_23", 2'b00, 4'h2, 4'h3, 8'h05, 1'b0, 1'b0);

    // Display scan of E1.
    run_op("mul_ff2", 2'b10, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0);
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`ifdef ALU_DISP_LZB_EN
    exp_seg = '{7'h79, 7'h06, 7'h7F, 7'h7F};
`else
    exp_seg = '{7'h79, 7'h06, 7'h40, 7'h40};
`endif
    found = 1'b0;
    prev = an;
    for (int t = 0; t < 64 && !found; t++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = an;
    end
    check("scan_align", 32'(found), 32'd1);
    if (found) begin
      for (int d = 0; d < 4; d++) begin
        for (int s = 0; s < 4; s++) begin
          if (d != 0 || s != 0) @(negedge clk);
          check($sformatf("scan_an_d%0d_s%0d", d, s), 32'(an), 32'(exp_an[d]));
          check($sformatf("scan_seg_d%0d_s%0d", d, s), 32'(sseg), 32'(exp_seg[d]));
        end
      end
    end

    repeat (10) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
